// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32 sequencer driving PC/IR/ALU/RF/DM controls with req/ack memory handshakes.
module core_seq_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ctrl_sig,
  input  logic        br_taken,
  output logic        if_req,
  input  logic        if_ack,
  output logic        dm_req,
  output logic        dm_we,
  input  logic        dm_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        instret,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  typedef enum logic [2:0] {C_ALU, C_LD, C_ST, C_BR, C_JALR, C_JAL, C_AUIPC, C_LUI} cls_t;
  state_t     state_q, state_d;
  cls_t       cls_q, cls_d, cls_dec;
  logic       a_q, a_d, b_q, b_d, br_q, br_d;
  logic       illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       a_dec, b_dec, wait_st, expire, in_wb, in_ops;
  logic       unused_ctrl;
  assign unused_ctrl = ^ctrl_sig[15:10];
  always_comb begin
    cls_dec = ctrl_sig[9] ? C_LUI : ctrl_sig[8] ? C_AUIPC : ctrl_sig[7] ? C_JAL : ctrl_sig[6] ? C_JALR :
              ctrl_sig[5] ? C_BR : ctrl_sig[4] ? C_ST : ctrl_sig[3] ? C_LD : C_ALU;
    a_dec = cls_dec == C_AUIPC;
    b_dec = (cls_dec == C_ALU) ? ctrl_sig[1] : (cls_dec inside {C_LD, C_ST, C_JALR, C_AUIPC});
    // one watchdog covers both wait states; it idles at zero elsewhere so it is clear on entry
    wait_st = (state_q == FETCH && !if_ack) || (state_q == MEM && !dm_ack);
    expire = wait_st && wcnt_q == TIMEOUT - 8'd1;
    wcnt_d = wait_st ? wcnt_q + 8'd1 : 8'd0;
    state_d = state_q;
    cls_d = cls_q;
    a_d = a_q;
    b_d = b_q;
    br_d = br_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q | expire;
    case (state_q)
      FETCH: state_d = expire ? HALT : if_ack ? DECODE : FETCH;
      DECODE: begin
        state_d = ctrl_sig[9:0] == 10'd0 ? HALT : EXEC;
        illegal_d = illegal_q | (ctrl_sig[9:0] == 10'd0);
        cls_d = cls_dec;
        a_d = a_dec;
        b_d = b_dec;
      end
      EXEC: begin
        br_d = br_taken;
        state_d = (cls_q == C_LD || cls_q == C_ST) ? MEM : WB;
      end
      MEM:  state_d = expire ? HALT : dm_ack ? WB : MEM;
      WB:   state_d = FETCH;
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    in_wb = state_q == WB;
    in_ops = state_q inside {EXEC, MEM, WB};
    if_req = state_q == FETCH;
    ir_we = if_req & if_ack;
    dm_req = state_q == MEM;
    dm_we = dm_req && cls_q == C_ST;
    pc_we = in_wb;
    instret = in_wb;
    rf_we = in_wb && !(cls_q inside {C_ST, C_BR});
    wb_sel = !in_wb ? 2'd0 : cls_q == C_LD ? 2'd1 : (cls_q inside {C_JAL, C_JALR}) ? 2'd2 :
             cls_q == C_LUI ? 2'd3 : 2'd0;
    pc_sel = !in_wb ? 2'd0 : (cls_q == C_JAL || (cls_q == C_BR && br_q)) ? 2'd1 :
             cls_q == C_JALR ? 2'd2 : 2'd0;
    // selects follow the live decode in DECODE, then the latched copy until WB
    alu_a_sel = state_q == DECODE ? a_dec : in_ops & a_q;
    alu_b_sel = state_q == DECODE ? b_dec : in_ops & b_q;
    illegal = illegal_q;
    bus_err = bus_err_q;
    state = state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cls_q <= C_ALU;
      a_q <= 1'b0;
      b_q <= 1'b0;
      br_q <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wcnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      a_q <= a_d;
      b_q <= b_d;
      br_q <= br_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wcnt_q <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: randomized scoreboard bench for core_seq_ctrl with a class-level reference model.
module tb_core_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] ctrl_sig = 16'd0;
  logic        br_taken = 1'b0, if_ack = 1'b0, dm_ack = 1'b0;
  logic        if_req, dm_req, dm_we, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, instret, illegal, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  always #5 clk = ~clk;
  core_seq_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_sig(ctrl_sig), .br_taken(br_taken),
    .if_req(if_req), .if_ack(if_ack), .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .illegal(illegal), .bus_err(bus_err), .state(state)
  );
  typedef struct {
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] pc_sel;
    logic       a;
    logic       b;
    int         dm_n;
    logic       dm_we;
    int         cycles;
  } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask
  function automatic exp_t model(input logic [15:0] c, input logic br, input int fw, input int mw);
    exp_t e;
    int   cls = 0;
    int   pri[7] = '{9, 8, 7, 6, 5, 4, 3};
    e.rf_we = 1'b1; e.wb_sel = 2'd0; e.pc_sel = 2'd0; e.a = 1'b0; e.b = 1'b0; e.dm_n = 0; e.dm_we = 1'b0;
    for (int i = 0; i < 7; i++) if (cls == 0 && c[pri[i]]) cls = pri[i];
    case (cls)
      9: e.wb_sel = 2'd3;
      8: begin e.a = 1'b1; e.b = 1'b1; end
      7: begin e.wb_sel = 2'd2; e.pc_sel = 2'd1; end
      6: begin e.wb_sel = 2'd2; e.pc_sel = 2'd2; e.b = 1'b1; end
      5: begin e.rf_we = 1'b0; e.pc_sel = br ? 2'd1 : 2'd0; end
      4: begin e.rf_we = 1'b0; e.b = 1'b1; e.dm_n = mw + 1; e.dm_we = 1'b1; end
      3: begin e.wb_sel = 2'd1; e.b = 1'b1; e.dm_n = mw + 1; end
      default: e.b = c[1];
    endcase
    e.cycles = 4 + fw + (e.dm_n > 0 ? 1 + mw : 0);
    return e;
  endfunction
  int   m_cyc = 0, m_ir = 0, m_dm = 0;
  logic m_we = 1'b0, m_a = 1'b0, m_b = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_ir = 0; m_dm = 0; m_we = 1'b0;
    end else begin
      m_cyc++;
      if (ir_we) m_ir++;
      if (dm_req) m_dm++;
      if (dm_we) m_we = 1'b1;
      if (state == 3'd1) begin m_a = alu_a_sel; m_b = alu_b_sel; end
      if (!instret) chk("strobes_idle", {30'd0, rf_we, pc_we}, 32'd0);
      else begin
        chk("pending_at_retire", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          me = exp_q.pop_front();
          chk("cycles", m_cyc, me.cycles);
          chk("rf_we", rf_we, me.rf_we);
          if (me.rf_we) chk("wb_sel", wb_sel, me.wb_sel);
          chk("pc_sel", pc_sel, me.pc_sel);
          chk("pc_we", pc_we, 1);
          chk("alu_a_dec", m_a, me.a);
          chk("alu_b_dec", m_b, me.b);
          chk("alu_a_wb", alu_a_sel, me.a);
          chk("alu_b_wb", alu_b_sel, me.b);
          chk("dm_cycles", m_dm, me.dm_n);
          chk("dm_we", m_we, me.dm_we);
          chk("ir_we_count", m_ir, 1);
        end
        m_cyc = 0; m_ir = 0; m_dm = 0; m_we = 1'b0;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0; if_ack = 1'b0; dm_ack = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_state", state, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_strobes", {pc_we, rf_we, instret, pc_sel, wb_sel}, 0);
    chk("rst_flags", {illegal, bus_err}, 0);
  endtask
  // drives FETCH (fw waits), DECODE and EXEC; returns in the cycle after EXEC
  task automatic go_exec(input logic [15:0] c, input logic br, input int fw);
    for (int i = 0; i < fw; i++) begin if_ack = 1'b0; dm_ack = 1'($urandom); tick; end
    if_ack = 1'b1; dm_ack = 1'($urandom); ctrl_sig = c; br_taken = br;
    tick;
    if_ack = 1'($urandom); dm_ack = 1'($urandom); br_taken = !br;
    tick;
    ctrl_sig = 16'($urandom); br_taken = br; if_ack = 1'($urandom); dm_ack = 1'($urandom);
    tick;
  endtask
  task automatic run_instr(input logic [15:0] c, input logic br, input int fw, input int mw);
    exp_t e;
    e = model(c, br, fw, mw);
    exp_q.push_back(e);
    go_exec(c, br, fw);
    if (e.dm_n > 0) begin
      for (int i = 0; i < mw; i++) begin dm_ack = 1'b0; if_ack = 1'($urandom); tick; end
      dm_ack = 1'b1; if_ack = 1'($urandom);
      tick;
    end
    if_ack = 1'($urandom); dm_ack = 1'($urandom); br_taken = !br;
    tick;
    if_ack = 1'b0;
  endtask
  task automatic hold_halt(input logic ill, input logic berr);
    for (int i = 0; i < 3; i++) begin
      if_ack = 1'($urandom); dm_ack = 1'($urandom);
      tick;
      chk("halt_state", state, 5);
      chk("halt_outputs", {if_req, dm_req, dm_we, pc_we, rf_we, instret}, 0);
      chk("halt_flags", {illegal, bus_err}, {30'd0, ill, berr});
    end
  endtask
  initial begin
    logic [15:0] c;
    tick;
    do_reset;
    run_instr(16'h0001, 1'b0, 0, 0);
    run_instr(16'h0008, 1'b0, 0, 3);
    run_instr(16'h0020, 1'b1, 0, 0);
    run_instr(16'h0020, 1'b0, 1, 0);
    run_instr(16'h0040, 1'b0, 0, 0);
    run_instr(16'h0300, 1'b1, 2, 0);
    run_instr(16'h0010, 1'b0, 3, 0);
    run_instr(16'h0080, 1'b0, 0, 0);
    run_instr(16'h0100, 1'b0, 0, 0);
    run_instr(16'h0003, 1'b0, 0, 0);
    run_instr(16'hfc04, 1'b0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      c = 16'($urandom);
      if ($urandom_range(1, 0) == 0) c[9:0] = 10'd1 << $urandom_range(9, 0);
      else c[9:0] = 10'($urandom_range(1023, 1));
      run_instr(c, 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0));
    end
    chk("queue_drained", exp_q.size(), 0);
    if_ack = 1'b1; ctrl_sig = 16'hfc00;
    tick;
    if_ack = 1'b0;
    tick;
    hold_halt(1'b1, 1'b0);
    do_reset;
    go_exec(16'h0010, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("wd_dm_req", {dm_req, dm_we, bus_err}, 3'b110);
      dm_ack = 1'b0; if_ack = 1'($urandom);
      tick;
    end
    chk("wd_bus_err", bus_err, 1);
    chk("wd_state", state, 5);
    chk("wd_dm_drop", dm_req, 0);
    hold_halt(1'b0, 1'b1);
    do_reset;
    for (int k = 0; k < 4; k++) begin
      chk("wd_if_req", {if_req, bus_err}, 2'b10);
      if_ack = 1'b0; dm_ack = 1'($urandom);
      tick;
    end
    chk("wd_fetch_err", {bus_err, state}, {1'b1, 3'd5});
    hold_halt(1'b0, 1'b1);
    do_reset;
    go_exec(16'h0008, 1'b0, 0);
    chk("mid_mem_req", dm_req, 1);
    do_reset;
    chk("mid_mem_drop", {dm_req, dm_we, ir_we}, 0);
    chk("queue_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded %0t", $time);
    $fatal(1);
  end
endmodule
